rx_chain_ctrl: RTL and testbench

Sequencer and strobe scheduler for one RX decimation channel. It holds the channel's run/rate register on the serial bus and generates `sample_strobe` and `decimator_strobe` for the chain. It also drives the chain's `enable` and `reset`, and flushes the CIC/halfband state whenever the rate changes. Its qualified output-valid pulse discards the filter warm-up samples before data reaches the RX FIFO packer.

---
 rtl/rx_chain_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_rx_chain_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_chain_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rx_chain_ctrl                                                   |
// | Purpose  : Run/rate control register, start-up sequencer and strobe        |
// |            scheduler for one RX decimation channel. Generates the chain    |
// |            enable/reset, sample and decimator strobes, and a qualified     |
// |            output-valid that discards filter warm-up samples.              |
// | Config   : RX_CHAIN_CTRL_SETTLE_MASK_EN builds the SETTLE state, which     |
// |            masks the first SETTLE_COUNT hb_strobe pulses after a restart.  |
// |            Without it, RESET goes straight to RUN.                          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module rx_chain_ctrl #(
  parameter logic [6:0] CTRLADDR     = 7'd40,
  parameter int         RESET_CYCLES = 4,
  parameter int         SETTLE_COUNT = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [6:0]  serial_addr,
  input  logic [31:0] serial_data,
  input  logic        serial_strobe,
  input  logic        hb_strobe,
  output logic        chain_enable,
  output logic        chain_reset,
  output logic        sample_strobe,
  output logic        decimator_strobe,
  output logic [7:0]  decim_rate,
  output logic        rx_valid,
  output logic        busy
);

  // Reset-hold counter counts down from RESET_CYCLES-1 to 0 while in RESET.
  localparam logic [7:0] RST_LOAD = 8'(RESET_CYCLES - 1);
`ifdef RX_CHAIN_CTRL_SETTLE_MASK_EN
  localparam logic [8:0] SETTLE_TARGET = 9'(SETTLE_COUNT);
`endif

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RESET  = 2'd1,
`ifdef RX_CHAIN_CTRL_SETTLE_MASK_EN
    ST_SETTLE = 2'd2,
`endif
    ST_RUN    = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] rate_q;
  logic [7:0] rst_cnt_q;
  logic [7:0] dec_cnt_q;
  logic       chain_reset_q;
  logic       chain_enable_q;
  logic       sample_strobe_q;
  logic       busy_q;

  logic       w_wr;
  logic       w_run;
  logic [7:0] w_rate;
  logic       w_rate_chg;
  logic [7:0] w_dec_load;
  logic       w_restart;
  logic       w_enabled_d;
  logic       w_busy_d;
  logic       w_unused;

  // Control register write decode; the run bit is carried by the FSM state.
  assign w_wr       = serial_strobe && (serial_addr == CTRLADDR);
  assign w_run      = serial_data[8];
  assign w_rate     = serial_data[7:0];
  assign w_rate_chg = (w_rate != rate_q);
  // Rates 0 and 1 both mean one decimator strobe per sample.
  assign w_dec_load = (rate_q == 8'd0) ? 8'd0 : (rate_q - 8'd1);

`ifdef RX_CHAIN_CTRL_SETTLE_MASK_EN
  logic [7:0] settle_cnt_q;
  logic       w_settle_done;
  // Leave SETTLE on the edge that sees the SETTLE_COUNT-th pulse, so the next pulse is valid.
  assign w_settle_done = (SETTLE_TARGET == 9'd0) ||
                         (hb_strobe && (({1'b0, settle_cnt_q} + 9'd1) >= SETTLE_TARGET));
  assign w_unused      = ^serial_data[31:9];
`else
  assign w_unused      = ^{serial_data[31:9], 8'(SETTLE_COUNT)};
`endif

  // Next-state decode; a run=0 write wins from every state.
  always_comb begin
    state_d   = state_q;
    w_restart = 1'b0;
    if (w_wr && !w_run) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_wr) begin
            state_d   = ST_RESET;
            w_restart = 1'b1;
          end
        end
        ST_RESET: begin
          if (w_wr && w_rate_chg) begin
            state_d   = ST_RESET;
            w_restart = 1'b1;
          end else if (rst_cnt_q == 8'd0) begin
`ifdef RX_CHAIN_CTRL_SETTLE_MASK_EN
            state_d = ST_SETTLE;
`else
            state_d = ST_RUN;
`endif
          end
        end
`ifdef RX_CHAIN_CTRL_SETTLE_MASK_EN
        ST_SETTLE: begin
          if (w_wr && w_rate_chg) begin
            state_d   = ST_RESET;
            w_restart = 1'b1;
          end else if (w_settle_done) begin
            state_d = ST_RUN;
          end
        end
`endif
        ST_RUN: begin
          if (w_wr && w_rate_chg) begin
            state_d   = ST_RESET;
            w_restart = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Chain drive and busy are decoded from the next state so they register with it.
`ifdef RX_CHAIN_CTRL_SETTLE_MASK_EN
  assign w_enabled_d = (state_d == ST_SETTLE) || (state_d == ST_RUN);
  assign w_busy_d    = (state_d == ST_RESET) || (state_d == ST_SETTLE);
`else
  assign w_enabled_d = (state_d == ST_RUN);
  assign w_busy_d    = (state_d == ST_RESET);
`endif

  // FSM state, control register, registered outputs and sequencing counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      rate_q          <= 8'd16;
      rst_cnt_q       <= 8'd0;
      dec_cnt_q       <= 8'd0;
      chain_reset_q   <= 1'b0;
      chain_enable_q  <= 1'b0;
      sample_strobe_q <= 1'b0;
      busy_q          <= 1'b0;
`ifdef RX_CHAIN_CTRL_SETTLE_MASK_EN
      settle_cnt_q    <= 8'd0;
`endif
    end else begin
      state_q         <= state_d;
      chain_reset_q   <= (state_d == ST_RESET);
      chain_enable_q  <= w_enabled_d;
      sample_strobe_q <= w_enabled_d;
      busy_q          <= w_busy_d;

      if (w_wr) begin
        rate_q <= w_rate;
      end

      // Reset hold: reload on every (re)start, count down while in RESET.
      if (w_restart) begin
        rst_cnt_q <= RST_LOAD;
      end else if ((state_q == ST_RESET) && (rst_cnt_q != 8'd0)) begin
        rst_cnt_q <= rst_cnt_q - 8'd1;
      end

      // Decimation: preset to N-1 during RESET, then count samples and wrap on zero.
      if (state_q == ST_RESET) begin
        dec_cnt_q <= w_dec_load;
      end else if (sample_strobe_q) begin
        dec_cnt_q <= (dec_cnt_q == 8'd0) ? w_dec_load : (dec_cnt_q - 8'd1);
      end

`ifdef RX_CHAIN_CTRL_SETTLE_MASK_EN
      // Warm-up pulse count is only meaningful inside SETTLE.
      if (state_q != ST_SETTLE) begin
        settle_cnt_q <= 8'd0;
      end else if (hb_strobe) begin
        settle_cnt_q <= settle_cnt_q + 8'd1;
      end
`endif
    end
  end

  assign chain_reset      = chain_reset_q;
  assign chain_enable     = chain_enable_q;
  assign sample_strobe    = sample_strobe_q;
  assign busy             = busy_q;
  assign decim_rate       = rate_q;
  assign decimator_strobe = sample_strobe_q && (dec_cnt_q == 8'd0);
  assign rx_valid         = hb_strobe && (state_q == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_rx_chain_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_rx_chain_ctrl                                                |
// | Purpose  : Self-checking bench for rx_chain_ctrl: vector table, directed   |
// |            corner sequences and random traffic against a reference model. |
// | Config   : follows RX_CHAIN_CTRL_SETTLE_MASK_EN like the design.           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_rx_chain_ctrl;

  localparam logic [6:0] ADDR = 7'd40;
  localparam int         RC   = 4;
  localparam int         SC   = 8;
`ifdef RX_CHAIN_CTRL_SETTLE_MASK_EN
  localparam bit SETTLE_EN = 1'b1;
`else
  localparam bit SETTLE_EN = 1'b0;
`endif

  localparam int M_IDLE = 0;
  localparam int M_RST  = 1;
  localparam int M_SET  = 2;
  localparam int M_RUN  = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic [6:0]  serial_addr;
  logic [31:0] serial_data;
  logic        serial_strobe;
  logic        hb_strobe;
  logic        chain_enable, chain_reset, sample_strobe, decimator_strobe;
  logic [7:0]  decim_rate;
  logic        rx_valid, busy;

  rx_chain_ctrl #(.CTRLADDR(ADDR), .RESET_CYCLES(RC), .SETTLE_COUNT(SC)) dut (
    .clock(clock), .reset(reset),
    .serial_addr(serial_addr), .serial_data(serial_data), .serial_strobe(serial_strobe),
    .hb_strobe(hb_strobe),
    .chain_enable(chain_enable), .chain_reset(chain_reset), .sample_strobe(sample_strobe),
    .decimator_strobe(decimator_strobe), .decim_rate(decim_rate),
    .rx_valid(rx_valid), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       rst;
    logic       en;
    logic       ss;
    logic       dec;
    logic       rxv;
    logic       busy;
    logic [7:0] rate;
  } outs_t;

  typedef struct {
    logic        stb;
    logic [6:0]  addr;
    logic [31:0] data;
    logic        hb;
    outs_t       exp;
  } vec_t;

  int    vectors = 0;
  int    miscompares = 0;
  outs_t seen;

  // Reference model: phase plus elapsed-time counters.
  int         m_phase, m_rcyc, m_pulses, m_k;
  logic [7:0] m_rate;

  task automatic model_reset();
    m_phase = M_IDLE; m_rcyc = 0; m_pulses = 0; m_k = 0; m_rate = 8'd16;
  endtask

  function automatic outs_t model_expect(input logic hb);
    outs_t e;
    int    n;
    n      = (m_rate == 8'd0) ? 1 : int'(m_rate);
    e.rst  = (m_phase == M_RST);
    e.en   = (m_phase == M_SET) || (m_phase == M_RUN);
    e.ss   = e.en;
    e.dec  = e.en && ((m_k % n) == (n - 1));
    e.rxv  = hb && (m_phase == M_RUN);
    e.busy = (m_phase == M_RST) || (m_phase == M_SET);
    e.rate = m_rate;
    return e;
  endfunction

  task automatic model_edge(input logic stb, input logic [6:0] a, input logic [31:0] d, input logic hb);
    int old;
    old = m_phase;
    case (old)
      M_RST: begin
        m_rcyc++;
        if (m_rcyc >= RC) begin
          m_k = 0; m_pulses = 0;
          m_phase = SETTLE_EN ? M_SET : M_RUN;
        end
      end
      M_SET: begin
        m_k++;
        if (hb) m_pulses++;
        if (m_pulses >= SC) m_phase = M_RUN;
      end
      M_RUN: m_k++;
      default: ;
    endcase
    if (stb && (a == ADDR)) begin
      if (!d[8]) m_phase = M_IDLE;
      else if ((old == M_IDLE) || (d[7:0] != m_rate)) begin
        m_phase = M_RST; m_rcyc = 0;
      end
      m_rate = d[7:0];
    end
  endtask

  function automatic outs_t mk(input logic r, input logic en, input logic dec, input logic b, input logic [7:0] rate);
    outs_t e;
    e.rst = r; e.en = en; e.ss = en; e.dec = dec; e.rxv = 1'b0; e.busy = b; e.rate = rate;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input outs_t e);
    check("chain_reset", 32'(chain_reset), 32'(e.rst));
    check("chain_enable", 32'(chain_enable), 32'(e.en));
    check("sample_strobe", 32'(sample_strobe), 32'(e.ss));
    check("decimator_strobe", 32'(decimator_strobe), 32'(e.dec));
    check("rx_valid", 32'(rx_valid), 32'(e.rxv));
    check("busy", 32'(busy), 32'(e.busy));
    check("decim_rate", 32'(decim_rate), 32'(e.rate));
  endtask

  // One clock: drive inputs, check mid-cycle, advance model on the edge.
  task automatic cycle(input logic stb, input logic [6:0] a, input logic [31:0] d, input logic hb,
                       input bit use_tbl, input outs_t texp);
    serial_strobe = stb; serial_addr = a; serial_data = d; hb_strobe = hb;
    #3;
    seen = {chain_reset, chain_enable, sample_strobe, decimator_strobe, rx_valid, busy, decim_rate};
    if (use_tbl) check_outs(texp);
    else         check_outs(model_expect(hb));
    @(posedge clock);
    model_edge(stb, a, d, hb);
    #1;
  endtask

  task automatic tick(input logic hb);
    cycle(1'b0, ADDR, 32'h0, hb, 1'b0, '0);
  endtask

  task automatic wr(input logic [31:0] d);
    cycle(1'b1, ADDR, d, 1'b0, 1'b0, '0);
  endtask

  // Stop, restart at rate r, rewrite the same rate midway; every gap must be N.
  task automatic period_check(input logic [7:0] r, input int ncyc);
    int prev, gmin, gmax, n;
    logic [31:0] d;
    n = (r == 8'd0) ? 1 : int'(r);
    d = {23'd0, 1'b1, r};
    wr({23'd0, 1'b0, r});
    wr(d);
    prev = -1; gmin = 1 << 30; gmax = 0;
    for (int i = 0; i < ncyc; i++) begin
      if (i == ncyc / 2) wr(d);
      else tick(1'b0);
      if (seen.dec) begin
        if (prev >= 0) begin
          if (i - prev < gmin) gmin = i - prev;
          if (i - prev > gmax) gmax = i - prev;
        end
        prev = i;
      end
    end
    check("dec_period_min", gmin, n);
    check("dec_period_max", gmax, n);
  endtask

  // Write d, then pulse hb every 10 clocks; return index of first pulse seen as valid.
  task automatic first_valid(input logic [31:0] d, input string name);
    int pulse, first;
    logic h;
    wr(d);
    pulse = 0; first = 0;
    for (int i = 0; i < 120; i++) begin
      h = ((i % 10) == 9);
      tick(h);
      if (h) begin
        pulse++;
        if (seen.rxv && first == 0) first = pulse;
      end
    end
    check(name, first, SETTLE_EN ? SC + 1 : 1);
  endtask

  vec_t tbl [13];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int          nrst;

    // Start sequence from reset, rate 0: address decode, 4-cycle reset, strobe every clock, stop.
    tbl[0]  = '{1'b0, ADDR,         32'h000, 1'b0, mk(0, 0, 0, 0, 8'd16)};
    tbl[1]  = '{1'b1, ADDR + 7'd1,  32'h1FF, 1'b0, mk(0, 0, 0, 0, 8'd16)};
    tbl[2]  = '{1'b0, ADDR,         32'h1FF, 1'b0, mk(0, 0, 0, 0, 8'd16)};
    tbl[3]  = '{1'b1, ADDR,         32'h100, 1'b0, mk(0, 0, 0, 0, 8'd16)};
    for (int i = 4; i < 8; i++)  tbl[i] = '{1'b0, ADDR, 32'h0, 1'b0, mk(1, 0, 0, 1, 8'd0)};
    for (int i = 8; i < 11; i++) tbl[i] = '{1'b0, ADDR, 32'h0, 1'b0, mk(0, 1, 1, SETTLE_EN, 8'd0)};
    tbl[11] = '{1'b1, ADDR,         32'h000, 1'b0, mk(0, 1, 1, SETTLE_EN, 8'd0)};
    tbl[12] = '{1'b0, ADDR,         32'h000, 1'b0, mk(0, 0, 0, 0, 8'd0)};

    reset = 1'b1; serial_addr = '0; serial_data = '0; serial_strobe = 1'b0; hb_strobe = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    for (int i = 0; i < 13; i++)
      cycle(tbl[i].stb, tbl[i].addr, tbl[i].data, tbl[i].hb, 1'b1, tbl[i].exp);

    // Decimation periods, including the rate 0/1 and 255 boundaries.
    period_check(8'd5, 80);
    period_check(8'd0, 30);
    period_check(8'd1, 30);
    period_check(8'd255, 800);

    // Settle mask from a cold start, then a rate change while running.
    wr(32'h000);
    first_valid(32'h108, "first_valid_start");
    wr(32'h105);
    for (int i = 0; i < 50; i++) tick((i % 3) == 2);
    first_valid(32'h108, "first_valid_rate_change");

    // Stop during SETTLE, then full restart.
    wr(32'h103);
    repeat (6) tick(1'b0);
    wr(32'h003);
    tick(1'b0);
    check("stopped_enable", 32'(seen.en), 32'h0);
    wr(32'h103);
    repeat (12) tick(1'b0);

    // Asynchronous reset mid-RUN.
    wr(32'h105);
    for (int i = 0; i < 30; i++) tick(i[0]);
    #2;
    hb_strobe = 1'b1;
    reset = 1'b1;
    #1;
    check_outs(mk(0, 0, 0, 0, 8'd16));
    @(posedge clock);
    #1 reset = 1'b0;
    hb_strobe = 1'b0;
    model_reset();
    wr(32'h110);
    nrst = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1'b0);
      if (seen.rst) nrst++;
    end
    check("reset_hold_cycles", nrst, RC);
    check("enable_after_reset", 32'(seen.en), 32'h1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      d = $urandom();
      case ($urandom_range(0, 6))
        0: d[7:0] = 8'd0;
        1: d[7:0] = 8'd1;
        2: d[7:0] = 8'd2;
        3: d[7:0] = 8'd5;
        4: d[7:0] = 8'd8;
        5: d[7:0] = decim_rate;
        default: ;
      endcase
      d[8] = ($urandom_range(0, 9) != 0);
      cycle(($urandom_range(0, 59) == 0),
            ($urandom_range(0, 9) == 0) ? ADDR + 7'd1 : ADDR,
            d, ($urandom_range(0, 3) == 0), 1'b0, '0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
